// File: rtl/operand_stack.sv
// LIFO operand stack serving the control unit's push/pop/stack_clk strobe interface.
// Optional OPERAND_STACK_SECOND_EN adds the registered second-from-top output data_second.
module operand_stack #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int PTR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rst,
   input  logic                  stack_clk,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_to_push,
   output logic [DATA_WIDTH-1:0] data_from_stack,
`ifdef OPERAND_STACK_SECOND_EN
   output logic [DATA_WIDTH-1:0] data_second,
`endif
   output logic [PTR_WIDTH:0]    count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_OP   = 2'd1;
   localparam logic [1:0] S_ERR  = 2'd2;

   localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0]   CNT_TWO  = (PTR_WIDTH+1)'(2);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_TWO  = PTR_WIDTH'(2);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  stb_q;
   logic [1:0]            state_q, state_d;
   logic [PTR_WIDTH-1:0]  sp_q, sp_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic [DATA_WIDTH-1:0] top_q, top_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;

   logic                  mem_we;
   logic [PTR_WIDTH-1:0]  mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] rd_second;

   logic                  event_w;
   logic                  is_empty;
   logic                  is_full;
   logic                  do_push;
   logic                  do_repl;
   logic                  do_pop;

   // A strobe held high produces a single event: only the 0->1 step counts.
   assign event_w  = stack_clk & ~stb_q;
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CNT_FULL);

   // push+pop on an empty stack degrades to a plain push.
   assign do_push = event_w & push & (~pop | is_empty);
   assign do_repl = event_w & push & pop & ~is_empty;
   assign do_pop  = event_w & pop & ~push;

   assign rd_second = mem_q[sp_q - PTR_TWO];

   always_comb begin
      sp_d      = sp_q;
      count_d   = count_q;
      top_d     = top_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_waddr = sp_q;
      mem_wdata = data_to_push;
      if (do_push) begin
         if (is_full) begin
            ovf_d = 1'b1;
         end else begin
            mem_we  = 1'b1;
            sp_d    = sp_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
            top_d   = data_to_push;
         end
      end else if (do_repl) begin
         mem_we    = 1'b1;
         mem_waddr = sp_q - PTR_ONE;
         top_d     = data_to_push;
      end else if (do_pop) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else if (count_q == CNT_ONE) begin
            sp_d    = '0;
            count_d = '0;
            top_d   = '0;
         end else begin
            sp_d    = sp_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
            top_d   = rd_second;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (event_w) state_d = S_OP;
         S_OP:    state_d = event_w ? S_OP : S_IDLE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
      // Error state is sticky until a clear, independent of further traffic.
      if (ovf_d || unf_d) state_d = S_ERR;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stb_q   <= 1'b0;
         state_q <= S_IDLE;
         sp_q    <= '0;
         count_q <= '0;
         top_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else if (rst) begin
         stb_q   <= 1'b0;
         state_q <= S_IDLE;
         sp_q    <= '0;
         count_q <= '0;
         top_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         stb_q   <= stack_clk;
         state_q <= state_d;
         sp_q    <= sp_d;
         count_q <= count_d;
         top_q   <= top_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is never cleared; only the pointer and count are.
   always_ff @(posedge clk) begin
      if (mem_we && !rst && !reset) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

`ifdef OPERAND_STACK_SECOND_EN
   localparam logic [PTR_WIDTH-1:0] PTR_THREE = PTR_WIDTH'(3);

   logic [DATA_WIDTH-1:0] sec_q, sec_d;
   logic [DATA_WIDTH-1:0] rd_third;

   assign rd_third = mem_q[sp_q - PTR_THREE];

   always_comb begin
      sec_d = sec_q;
      if (do_push && !is_full) begin
         sec_d = top_q;
      end else if (do_pop && !is_empty) begin
         sec_d = (count_q <= CNT_TWO) ? '0 : rd_third;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_q <= '0;
      end else if (rst) begin
         sec_q <= '0;
      end else begin
         sec_q <= sec_d;
      end
   end

   assign data_second = sec_q;
`endif

   assign data_from_stack = top_q;
   assign count           = count_q;
   assign empty           = is_empty;
   assign full            = is_full;
   assign overflow        = ovf_q;
   assign underflow       = unf_q;

endmodule
